// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//   RV32 instruction encoder. It is the inverse of an immediate generator: it
//   packs an opcode, register fields and a byte-level immediate into one
//   32-bit instruction word for the I/S/B/U/J formats. It also expands the LI
//   pseudo-instruction into ADDI, LUI, or LUI followed by ADDI. Immediates
//   that cannot be encoded produce a single error word.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   in_valid     : request valid
//   in_ready     : request can be accepted (combinational)
//   in_fmt       : 0=I 1=S 2=B 3=U 4=J 5=LI, 6/7 reserved (always illegal)
//   in_opcode    : opcode for I/S/B/U/J (ignored for LI)
//   in_funct3    : funct3 for I/S/B (ignored otherwise)
//   in_rd/rs1/rs2: register fields
//   in_imm       : two's-complement byte-level immediate/offset
//   out_valid    : output word valid
//   out_ready    : consumer accepts the word
//   out_instr    : encoded instruction (0 on error)
//   out_err      : immediate illegal for the format, or reserved format
//   out_last     : final word of the current request
// ----------------------------------------------------------------------------
module instr_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic [1:0] {
    IDLE,   // output register empty
    HOLD,   // single or final word held
    LI_HI   // LUI word held, ADDI pending
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] r_pend,  w_pend_nxt;
  logic        r_err,   w_err_nxt;
  logic        r_last,  w_last_nxt;

  // Range checks: the immediate fits N signed bits when all bits from
  // position N-1 upward equal the sign bit.
  logic w_fits12, w_fits13, w_fits21;
  assign w_fits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign w_fits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign w_fits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  // LUI upper part for LI: (imm + 0x800) >> 12. Adding imm[11] to the upper
  // 20 bits compensates for ADDI sign-extending its 12-bit immediate.
  logic [19:0] w_li_hi;
  assign w_li_hi = in_imm[31:12] + {19'd0, in_imm[11]};

  logic [31:0] w_word0, w_word1;
  logic        w_err, w_two;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_word0 = '0;
    w_word1 = '0;
    w_err   = 1'b0;
    w_two   = 1'b0;
    case (in_fmt)
      3'd0: begin
        w_word0 = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        w_err   = !w_fits12;
      end
      3'd1: begin
        w_word0 = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_err   = !w_fits12;
      end
      3'd2: begin
        w_word0 = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                   in_imm[4:1], in_imm[11], in_opcode};
        w_err   = !w_fits13 || in_imm[0];
      end
      3'd3: begin
        w_word0 = {in_imm[31:12], in_rd, in_opcode};
        w_err   = |in_imm[11:0];
      end
      3'd4: begin
        w_word0 = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_err   = !w_fits21 || in_imm[0];
      end
      3'd5: begin
        if (w_fits12) begin
          w_word0 = {in_imm[11:0], 5'd0, 3'b000, in_rd, OP_IMM};
        end else begin
          w_word0 = {w_li_hi, in_rd, OP_LUI};
          // A zero low part needs no ADDI.
          w_two   = |in_imm[11:0];
          w_word1 = {in_imm[11:0], in_rd, 3'b000, in_rd, OP_IMM};
        end
      end
      default: w_err = 1'b1;
    endcase
    if (w_err) w_word0 = '0;
  end

  // A new request can be taken only when the output register is empty or its
  // single/final word leaves this cycle; LI_HI must first emit its ADDI.
  logic w_accept;
  assign in_ready = (r_state == IDLE) || (r_state == HOLD && out_ready);
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_instr_nxt = r_instr;
    w_pend_nxt  = r_pend;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last;
    if (w_accept) begin
      w_instr_nxt = w_word0;
      w_err_nxt   = w_err;
      w_last_nxt  = !w_two;
      w_pend_nxt  = w_word1;
      w_state_nxt = w_two ? LI_HI : HOLD;
    end else if (out_ready) begin
      case (r_state)
        HOLD:  w_state_nxt = IDLE;
        LI_HI: begin
          w_instr_nxt = r_pend;
          w_err_nxt   = 1'b0;
          w_last_nxt  = 1'b1;
          w_state_nxt = HOLD;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_instr <= '0;
      r_pend  <= '0;
      r_err   <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_instr <= w_instr_nxt;
      r_pend  <= w_pend_nxt;
      r_err   <= w_err_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign out_valid = (r_state != IDLE);
  assign out_instr = r_instr;
  assign out_err   = r_err;
  assign out_last  = r_last;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder. Directed vectors come from a table
//   of literal expected words. Hand sequences cover LI hold-off, throughput,
//   stall and reset during LI. A random legal stream is checked by decoding
//   the immediate back out of each word. Expected words are queued when a
//   request is driven and popped when the DUT hands a word over.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  instr_encoder dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    req_t        r;
    int          n;
    logic [31:0] w0, w1;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
    bit          rt;    // round-trip check instead of exact word
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  opc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(3) != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] fmt);
    case (fmt)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'd0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // Scoreboard: a word leaves the DUT at the coming edge when valid&&ready.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected no word", out_instr);
      end else begin
        e = sb.pop_front();
        if (e.rt) begin
          check("rt_err",    32'(out_err),   32'(1'b0));
          check("rt_last",   32'(out_last),  32'(1'b1));
          check("rt_opcode", 32'(out_instr[6:0]), 32'(e.opc));
          check("rt_imm",    imm_gen(out_instr, e.fmt), e.imm);
        end else begin
          check("word", out_instr,       e.instr);
          check("err",  32'(out_err),    32'(e.err));
          check("last", 32'(out_last),   32'(e.last));
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input logic err, input logic last);
    exp_t e;
    e = '{instr: w, err: err, last: last, rt: 1'b0, fmt: 3'd0, imm: 32'd0, opc: 7'd0};
    sb.push_back(e);
  endtask

  task automatic drive(input req_t r);
    in_fmt    = r.fmt;
    in_opcode = r.opc;
    in_funct3 = r.f3;
    in_rd     = r.rd;
    in_rs1    = r.rs1;
    in_rs2    = r.rs2;
    in_imm    = r.imm;
    in_valid  = 1'b1;
  endtask

  // Hold the request until the DUT takes it; returns #1 after the accepting edge.
  task automatic send(input req_t r, output int acc_cyc);
    bit ok;
    ok = 0;
    acc_cyc = -1;
    drive(r);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
        acc_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d words pending expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];

  initial begin
    int   acc, first_acc, last_acc;
    req_t r;
    logic [31:0] rnd;
    exp_t e;

    vecs[0]  = '{'{3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF}, 1, 32'hFFF00093, 32'h0, 1'b0};
    vecs[1]  = '{'{3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00000008}, 1, 32'h00208463, 32'h0, 1'b0};
    vecs[2]  = '{'{3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF}, 2, 32'h123462B7, 32'hFFF28293, 1'b0};
    vecs[3]  = '{'{3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h000007FF}, 1, 32'h7FF00093, 32'h0, 1'b0};
    vecs[4]  = '{'{3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00001000}, 1, 32'h000010B7, 32'h0, 1'b0};
    vecs[5]  = '{'{3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'h00000003}, 1, 32'h00000000, 32'h0, 1'b1};
    vecs[6]  = '{'{3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800}, 1, 32'h00000000, 32'h0, 1'b1};
    vecs[7]  = '{'{3'd3, 7'h37, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00001001}, 1, 32'h00000000, 32'h0, 1'b1};
    vecs[8]  = '{'{3'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000000}, 1, 32'h00000000, 32'h0, 1'b1};
    vecs[9]  = '{'{3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd5, 32'hFFFFFFFC}, 1, 32'hFE512E23, 32'h0, 1'b0};
    vecs[10] = '{'{3'd3, 7'h37, 3'd0, 5'd3, 5'd0, 5'd0, 32'hABCDE000}, 1, 32'hABCDE1B7, 32'h0, 1'b0};
    vecs[11] = '{'{3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h00000800}, 1, 32'h001000EF, 32'h0, 1'b0};
    vecs[12] = '{'{3'd2, 7'h63, 3'd1, 5'd0, 5'd0, 5'd0, 32'h00000FFE}, 1, 32'h7E001FE3, 32'h0, 1'b0};
    vecs[13] = '{'{3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00001000}, 1, 32'h00000000, 32'h0, 1'b1};
    vecs[14] = '{'{3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFF00000}, 1, 32'h8000006F, 32'h0, 1'b0};
    vecs[15] = '{'{3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h00100000}, 1, 32'h00000000, 32'h0, 1'b1};
    vecs[16] = '{'{3'd0, 7'h13, 3'd0, 5'd2, 5'd3, 5'd0, 32'hFFFFF800}, 1, 32'h80018113, 32'h0, 1'b0};
    vecs[17] = '{'{3'd5, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFF800}, 1, 32'h80000013, 32'h0, 1'b0};
    vecs[18] = '{'{3'd5, 7'h00, 3'd0, 5'd7, 5'd0, 5'd0, 32'h00000800}, 2, 32'h000013B7, 32'h80038393, 1'b0};
    vecs[19] = '{'{3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF7FF}, 1, 32'h00000000, 32'h0, 1'b1};

    in_valid = 0; in_fmt = 0; in_opcode = 0; in_funct3 = 0;
    in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(1'b0));
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_err",   32'(out_err),   32'(1'b0));
    check("rst_out_last",  32'(out_last),  32'(1'b0));
    check("rst_in_ready",  32'(in_ready),  32'(1'b1));
    @(posedge clk); #1;

    // Directed table: exact words, latency 1
    for (int i = 0; i < 20; i++) begin
      if (vecs[i].n == 2) begin
        push_word(vecs[i].w0, 1'b0, 1'b0);
        push_word(vecs[i].w1, 1'b0, 1'b1);
      end else begin
        push_word(vecs[i].w0, vecs[i].err, 1'b1);
      end
      send(vecs[i].r, acc);
      @(negedge clk);
      check("latency_valid", 32'(out_valid), 32'(1'b1));
      drain();
    end

    // LI: in_ready stays low while the LUI word is held
    out_ready = 1'b0;
    push_word(32'h123462B7, 1'b0, 1'b0);
    push_word(32'hFFF28293, 1'b0, 1'b1);
    send(vecs[2].r, acc);
    @(negedge clk);
    check("li_hi_valid",  32'(out_valid), 32'(1'b1));
    check("li_hi_last",   32'(out_last),  32'(1'b0));
    check("li_hi_ready0", 32'(in_ready),  32'(1'b0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("li_hi_ready1", 32'(in_ready),  32'(1'b0));
    drain();

    // Throughput: four single-word requests back-to-back
    first_acc = 0;
    last_acc  = 0;
    for (int i = 0; i < 4; i++) begin
      r = '{3'd0, 7'h13, 3'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1)};
      push_word((32'(i + 1) << 20) | (32'(i + 1) << 7) | 32'h13, 1'b0, 1'b1);
      send(r, acc);
      if (i == 0) first_acc = acc;
      last_acc = acc;
    end
    check("throughput_cycles", 32'(last_acc - first_acc), 32'd3);
    drain();

    // Stall: word A held for 3 cycles with B waiting
    out_ready = 1'b0;
    push_word(32'h00500213, 1'b0, 1'b1);
    r = '{3'd0, 7'h13, 3'd0, 5'd4, 5'd0, 5'd0, 32'd5};
    send(r, acc);
    r = '{3'd0, 7'h13, 3'd0, 5'd6, 5'd4, 5'd0, 32'hFFFFFFFF};
    drive(r);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_instr",    out_instr,      32'h00500213);
      check("stall_valid",    32'(out_valid), 32'(1'b1));
      check("stall_in_ready", 32'(in_ready),  32'(1'b0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    push_word(32'hFFF20313, 1'b0, 1'b1);
    send(r, acc);
    drain();

    // Reset while the LUI word of an LI is presented
    out_ready = 1'b0;
    send(vecs[2].r, acc);
    @(negedge clk);
    check("pre_rst_last", 32'(out_last), 32'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    check("li_rst_valid",    32'(out_valid), 32'(1'b0));
    check("li_rst_instr",    out_instr,      32'h0);
    check("li_rst_in_ready", 32'(in_ready),  32'(1'b1));
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("li_rst_no_addi", 32'(out_valid), 32'(1'b0));
    @(posedge clk); #1;

    // Random legal stream, checked by immediate round-trip
    rand_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom;
      r.fmt = 3'($urandom_range(4));
      r.f3  = rnd[2:0];
      r.rd  = rnd[7:3];
      r.rs1 = rnd[12:8];
      r.rs2 = rnd[17:13];
      case (r.fmt)
        3'd0: begin r.opc = 7'h13; r.imm = 32'(int'($urandom_range(4095)) - 2048); end
        3'd1: begin r.opc = 7'h23; r.imm = 32'(int'($urandom_range(4095)) - 2048); end
        3'd2: begin r.opc = 7'h63; r.imm = 32'((int'($urandom_range(4095)) - 2048) * 2); end
        3'd3: begin r.opc = 7'h37; rnd = $urandom; r.imm = {rnd[19:0], 12'd0}; end
        default: begin
          r.opc = 7'h6F;
          r.imm = 32'((int'($urandom_range(1048575)) - 524288) * 2);
        end
      endcase
      e = '{instr: 32'd0, err: 1'b0, last: 1'b1, rt: 1'b1, fmt: r.fmt, imm: r.imm, opc: r.opc};
      sb.push_back(e);
      send(r, acc);
    end
    rand_ready = 0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
